// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with configurable wait states and
// two-cycle ERROR response.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no data phase in flight, HREADYOUT=1, HRESP=OKAY
// WAIT  | legal transfer accepted, stalling for WAIT_STATES cycles
// DATA  | data-phase completion: read data driven, write commits here
// ERR1  | first ERROR cycle, HREADYOUT=0
// ERR2  | second ERROR cycle, HREADYOUT=1, may accept next transfer
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [WORD_W-1:0] word_addr;
  logic              accept;
  logic              illegal;
  logic [3:0]        be;
  logic              mem_we;
  logic              unused_htrans;

  // Only HTRANS[1] distinguishes an active transfer (NONSEQ/SEQ) from IDLE/BUSY.
  assign unused_htrans = HTRANS[0];
  assign word_addr     = HADDR[ADDR_WIDTH-1:2];
  assign accept        = HSEL & HREADY & HTRANS[1];

  // Transfer legality, evaluated on the address phase.
  always_comb begin
    illegal = 1'b0;
    if (HSIZE > 3'd2)                            illegal = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])             illegal = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) illegal = 1'b1;
    if (word_addr >= DEPTH_W)                    illegal = 1'b1;
  end

  // Next-state, latched controls and wait counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new address
        // phase may be accepted and pipelined straight in.
        state_d = ST_IDLE;
        if (accept) begin
          idx_d  = word_addr[IDX_W-1:0];
          off_d  = HADDR[1:0];
          size_d = HSIZE;
          if (illegal) begin
            state_d = ST_ERR1;
            write_d = 1'b0;
          end else begin
            write_d = HWRITE;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
    endcase
    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // FSM and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      off_q       <= 2'b00;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Little-endian byte lanes from latched size and offset.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be = 4'b0001 << off_q;
      3'd1:    be = 4'b0011 << off_q;
      default: be = 4'b1111;
    endcase
  end

  // Writes commit on the edge that ends DATA; reset forces IDLE first, so an
  // aborted write never reaches the array.
  assign mem_we = (state_q == ST_DATA) && write_q;

  // Array write with per-lane enables; the array itself is not reset.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[idx_q][8*n +: 8] <= HWDATA[8*n +: 8];
      end
    end
  end

  assign HRDATA    = (state_q == ST_DATA) ? mem[idx_q] : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances (0, 1, 3 wait states)
// share one bus; the "cur" instance is selected and monitored.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hold;
  int          cur;

  logic [31:0] hrdata_i [3];
  logic        hro_i    [3];
  logic        hresp_i  [3];

  logic [31:0] hrdata_c;
  logic        hro_c, hresp_c, hready_c;

  int ws_tab [3] = '{1, 0, 3};

  always #5 clk = ~clk;

  assign hrdata_c = hrdata_i[cur];
  assign hro_c    = hro_i[cur];
  assign hresp_c  = hresp_i[cur];
  assign hready_c = hro_c & ~hold;

  ahb_sram_slave #(.WAIT_STATES(1)) u_ws1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && cur == 0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(hro_i[0] & ~hold), .HRDATA(hrdata_i[0]), .HREADYOUT(hro_i[0]),
    .HRESP(hresp_i[0]));

  ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && cur == 1), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(hro_i[1] & ~hold), .HRDATA(hrdata_i[1]), .HREADYOUT(hro_i[1]),
    .HRESP(hresp_i[1]));

  ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel && cur == 2), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HREADY(hro_i[2] & ~hold), .HRDATA(hrdata_i[2]), .HREADYOUT(hro_i[2]),
    .HRESP(hresp_i[2]));

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [3][16];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, cur, $time, act, exp);
    end
  endtask

  // Waits for a cycle with HREADY high, then steps just past that edge.
  task automatic wait_ready(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (hready_c) break;
      n++;
      if (n > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout inst=%0d got=hready_low want=hready_high", name, cur);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one address phase, predicting its response from the rules.
  task automatic addr_phase(input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                            input logic [31:0] wd);
    exp_t        e;
    bit          bad;
    int unsigned w, off, nb;
    w   = addr >> 2;
    off = addr % 4;
    bad = (sz > 3'd2) || (sz == 3'd1 && addr % 2 != 0) || (sz == 3'd2 && off != 0) || (w >= 256);
    e.err   = bad;
    e.rd    = !wr && !bad;
    e.data  = (!bad && w < 16) ? model[cur][w] : 32'h0;
    e.waits = bad ? 1 : ws_tab[cur];
    if (wr && !bad && w < 16) begin
      nb = 1 << sz;
      for (int n = off; n < off + nb; n++) model[cur][w][8*n +: 8] = wd[8*n +: 8];
    end
    sb.push_back(e);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = sz;
    wait_ready("accept");
    hwdata = wr ? wd : $urandom;
  endtask

  task automatic idle_end();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    wait_ready("drain");
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops an expectation at each accept and checks it at completion.
  exp_t cx;
  bit   busy = 1'b0;
  int   waits = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        sb.delete();
      end else begin
        if (busy) begin
          if (!hro_c) begin
            waits++;
            check("wait_hresp", 32'(hresp_c), 32'(cx.err));
            check("wait_hrdata", hrdata_c, 32'h0);
          end else begin
            check("resp", 32'(hresp_c), 32'(cx.err));
            check("wait_count", 32'(waits), 32'(cx.waits));
            if (cx.rd) check("rdata", hrdata_c, cx.data);
            busy = 1'b0;
          end
        end else begin
          check("idle_hready", 32'(hro_c), 32'h1);
          check("idle_hresp", 32'(hresp_c), 32'h0);
          check("idle_hrdata", hrdata_c, 32'h0);
        end
        if (hsel && htrans[1] && hready_c) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty inst=%0d got=accept want=expectation", cur);
          end else begin
            cx    = sb.pop_front();
            busy  = 1'b1;
            waits = 0;
          end
        end
      end
    end
  end

  initial begin
    bit          wr;
    logic [31:0] a, wd;
    logic [2:0]  sz;
    exp_t        ab;

    rst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hwdata = '0; hold = 1'b0; cur = 0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_hready", 32'(hro_i[k]), 32'h1);
      check("rst_hresp", 32'(hresp_i[k]), 32'h0);
      check("rst_hrdata", hrdata_i[k], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Give every instance known contents in words 0..15.
    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int w = 0; w < 16; w++) addr_phase(1'b1, 32'(w * 4), 3'd2, $urandom);
      idle_end();
    end

    // One wait state: word write/read, byte and halfword merges.
    cur = 0;
    addr_phase(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    addr_phase(1'b0, 32'h10, 3'd2, 32'h0);
    idle_end();
    addr_phase(1'b1, 32'h10, 3'd2, 32'h11223344);
    addr_phase(1'b1, 32'h11, 3'd0, 32'h0000AA00);
    addr_phase(1'b0, 32'h10, 3'd2, 32'h0);
    addr_phase(1'b1, 32'h12, 3'd1, 32'hBEEF0000);
    addr_phase(1'b0, 32'h10, 3'd2, 32'h0);
    idle_end();

    // Illegal transfers, then confirm memory untouched.
    addr_phase(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF);
    addr_phase(1'b0, 32'h400, 3'd2, 32'h0);
    addr_phase(1'b1, 32'h10, 3'd3, 32'h0BADF00D);
    addr_phase(1'b1, 32'h401, 3'd1, 32'h12345678);
    addr_phase(1'b0, 32'h00, 3'd2, 32'h0);
    addr_phase(1'b0, 32'h10, 3'd2, 32'h0);
    idle_end();

    // Non-transfers: IDLE/BUSY while selected, NONSEQ while deselected,
    // and NONSEQ while another slave holds HREADY low.
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; hwdata = 32'h0;
    idle_cycles(2);
    htrans = 2'b01;
    idle_cycles(2);
    hsel = 1'b0; htrans = 2'b10;
    idle_cycles(2);
    hsel = 1'b1; hold = 1'b1;
    idle_cycles(3);
    htrans = 2'b00; hsel = 1'b0; hold = 1'b0;
    idle_cycles(1);
    addr_phase(1'b0, 32'h10, 3'd2, 32'h0);
    idle_end();

    // Zero wait states: back-to-back reads complete on consecutive cycles.
    cur = 1;
    addr_phase(1'b0, 32'h0, 3'd2, 32'h0);
    addr_phase(1'b0, 32'h4, 3'd2, 32'h0);
    addr_phase(1'b0, 32'h8, 3'd2, 32'h0);
    idle_end();
    addr_phase(1'b1, 32'h8, 3'd2, 32'hCAFEF00D);
    addr_phase(1'b0, 32'h8, 3'd2, 32'h0);
    addr_phase(1'b1, 32'h3, 3'd2, 32'h0);
    addr_phase(1'b0, 32'h8, 3'd2, 32'h0);
    idle_end();

    // Three wait states: reset during the second WAIT cycle of a write.
    cur = 2;
    addr_phase(1'b1, 32'h20, 3'd2, 32'h0);
    idle_end();
    ab.err = 1'b0; ab.rd = 1'b0; ab.data = 32'h0; ab.waits = 3;
    sb.push_back(ab);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    wait_ready("abort_accept");
    hwdata = 32'h55555555; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    @(posedge clk);
    #2;
    check("abort_pre_hready", 32'(hro_c), 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort_hready", 32'(hro_c), 32'h1);
    check("abort_hresp", 32'(hresp_c), 32'h0);
    check("abort_hrdata", hrdata_c, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    addr_phase(1'b0, 32'h20, 3'd2, 32'h0);
    idle_end();

    // Randomized traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int i = 0; i < 80; i++) begin
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 3'd1) a[0] = 1'b0;
          if (sz == 3'd2) a[1:0] = 2'b00;
        end
        if ($urandom_range(0, 11) == 0) a = 32'h400 + 32'($urandom_range(0, 15) * 4);
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        addr_phase(wr, a, sz, wd);
        if ($urandom_range(0, 4) == 0) begin
          idle_end();
          idle_cycles($urandom_range(0, 2));
        end
      end
      idle_end();
    end

    idle_cycles(2);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
